// File: rtl/alarm_latch_ctrl.sv
// Alarm latch controller: qualifies the upstream alarm condition over consecutive clocks,
// latches an alarm, drives the lamp and the blinking buzzer until acknowledged, and counts alarms.
module alarm_latch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BLINK_HALF      = 8,
   parameter int EVT_W           = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_a,
   input  logic             i_ack,
   output logic             o_lamp,
   output logic             o_buzz,
   output logic [EVT_W-1:0] o_events,
   output logic [1:0]       o_st
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_QUAL  = 2'b01;
   localparam logic [1:0] ST_ALARM = 2'b10;
   localparam logic [1:0] ST_ACKED = 2'b11;

   // Last count values are compared before incrementing, so the compare fires on the edge
   // where the incremented value would reach the parameter.
   localparam logic [7:0]       QCNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]       BLINK_LAST = 8'(BLINK_HALF - 1);
   localparam logic [7:0]       CNT_ONE    = 8'd1;
   localparam logic [EVT_W-1:0] EVT_ONE    = {{(EVT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_st;
   logic [7:0]       r_qcnt;
   logic [7:0]       r_blink;
   logic             r_buzz;
   logic [EVT_W-1:0] r_events;

   // Single state/datapath register block; entering ALARM counts the event and restarts the blink.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_st     <= ST_IDLE;
         r_qcnt   <= '0;
         r_blink  <= '0;
         r_buzz   <= 1'b0;
         r_events <= '0;
      end else begin
         case (r_st)
            ST_IDLE: begin
               if (i_a) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     r_st     <= ST_ALARM;
                     r_events <= r_events + EVT_ONE;
                     r_buzz   <= 1'b1;
                     r_blink  <= '0;
                     r_qcnt   <= '0;
                  end else begin
                     r_st   <= ST_QUAL;
                     r_qcnt <= CNT_ONE;
                  end
               end
            end
            ST_QUAL: begin
               if (!i_a) begin
                  r_st   <= ST_IDLE;
                  r_qcnt <= '0;
               end else if (r_qcnt == QCNT_LAST) begin
                  r_st     <= ST_ALARM;
                  r_events <= r_events + EVT_ONE;
                  r_buzz   <= 1'b1;
                  r_blink  <= '0;
                  r_qcnt   <= '0;
               end else begin
                  r_qcnt <= r_qcnt + CNT_ONE;
               end
            end
            ST_ALARM: begin
               if (i_ack) begin
                  r_st    <= ST_ACKED;
                  r_buzz  <= 1'b0;
                  r_blink <= '0;
               end else if (r_blink == BLINK_LAST) begin
                  r_blink <= '0;
                  r_buzz  <= ~r_buzz;
               end else begin
                  r_blink <= r_blink + CNT_ONE;
               end
            end
            default: begin
               if (!i_a) begin
                  r_st <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Lamp is the upper state bit: set in both ALARM and ACKED.
   assign o_lamp   = r_st[1];
   assign o_buzz   = r_buzz;
   assign o_events = r_events;
   assign o_st     = r_st;

endmodule

// File: tb/tb_alarm_latch_ctrl.sv
// Self-checking bench for alarm_latch_ctrl: two instances (default and single-cycle debounce)
// compared against a behavioural model built from the alarm rules.
module tb_alarm_latch_ctrl;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic a0 = 1'b0, ack0 = 1'b0, a1 = 1'b0, ack1 = 1'b0;
   logic lamp0, buzz0, lamp1, buzz1;
   logic [7:0] ev0, ev1;
   logic [1:0] st0, st1;
   logic [11:0] dut0, dut1;

   int checks = 0;
   int errors = 0;

   // Behavioural model state, index 0 = default instance, index 1 = debounce-1 instance
   int mRun[2];
   bit mLatched[2];
   bit mAcked[2];
   int mAge[2];
   int mEv[2];
   int dbc[2] = '{4, 1};
   int bhf[2] = '{8, 3};

   always #5 clk = ~clk;

   alarm_latch_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_HALF(8), .EVT_W(8)) dutA (
      .i_clk(clk), .i_rst_n(rstN), .i_a(a0), .i_ack(ack0),
      .o_lamp(lamp0), .o_buzz(buzz0), .o_events(ev0), .o_st(st0)
   );

   alarm_latch_ctrl #(.DEBOUNCE_CYCLES(1), .BLINK_HALF(3), .EVT_W(8)) dutB (
      .i_clk(clk), .i_rst_n(rstN), .i_a(a1), .i_ack(ack1),
      .o_lamp(lamp1), .o_buzz(buzz1), .o_events(ev1), .o_st(st1)
   );

   assign dut0 = {st0, lamp0, buzz0, ev0};
   assign dut1 = {st1, lamp1, buzz1, ev1};

   function automatic void resetModel();
      for (int i = 0; i < 2; i++) begin
         mRun[i] = 0; mLatched[i] = 0; mAcked[i] = 0; mAge[i] = 0; mEv[i] = 0;
      end
   endfunction

   // One clock of the alarm rules: count consecutive highs, latch, age the blink, ack, release.
   function automatic void stepModel(int i, logic a, logic ack);
      if (!mLatched[i]) begin
         if (a) begin
            mRun[i]++;
            if (mRun[i] >= dbc[i]) begin
               mLatched[i] = 1; mAcked[i] = 0; mAge[i] = 0; mRun[i] = 0;
               mEv[i] = (mEv[i] + 1) % 256;
            end
         end else begin
            mRun[i] = 0;
         end
      end else if (!mAcked[i]) begin
         if (ack) mAcked[i] = 1;
         else mAge[i]++;
      end else if (!a) begin
         mLatched[i] = 0; mAcked[i] = 0;
      end
   endfunction

   // Expected {St, Lamp, Buzz, Events}
   function automatic logic [11:0] expVec(int i);
      logic [1:0] s;
      logic b;
      if (mLatched[i]) s = mAcked[i] ? 2'b11 : 2'b10;
      else s = (mRun[i] > 0) ? 2'b01 : 2'b00;
      b = mLatched[i] && !mAcked[i] && (((mAge[i] / bhf[i]) % 2) == 0);
      return {s, mLatched[i] ? 1'b1 : 1'b0, b, 8'(mEv[i])};
   endfunction

   // Drive inputs, take one rising edge, advance the model, settle 1ns past the edge.
   task automatic tick(input logic na0, input logic nack0, input logic na1, input logic nack1);
      a0 = na0; ack0 = nack0; a1 = na1; ack1 = nack1;
      @(posedge clk);
      if (rstN) begin
         stepModel(0, na0, nack0);
         stepModel(1, na1, nack1);
      end
      #1;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      #12;
      checks++;
      if (dut0 !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_inst0 got=%h exp=%h", dut0, 12'h000);
      end
      checks++;
      if (dut1 !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_inst1 got=%h exp=%h", dut1, 12'h000);
      end
      resetModel();
      rstN = 1'b1;
   endtask

   task automatic test_qualification();
      logic pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
      for (int k = 0; k < 4; k++) begin
         tick(1, 0, 0, 0);
         checks++;
         if (dut0 !== expVec(0)) begin
            errors++;
            $display("[TB] FAIL qual_edge%0d got=%h exp=%h", k + 1, dut0, expVec(0));
         end
      end
      checks++;
      if (dut0 !== {2'b10, 1'b1, 1'b1, 8'd1}) begin
         errors++;
         $display("[TB] FAIL qual_latched got=%h exp=%h", dut0, {2'b10, 1'b1, 1'b1, 8'd1});
      end
      tick(1, 1, 0, 0);
      tick(0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         tick(pat[k], 0, 0, 0);
         checks++;
         if (dut0 !== expVec(0)) begin
            errors++;
            $display("[TB] FAIL qual_gap_step%0d got=%h exp=%h", k, dut0, expVec(0));
         end
      end
      checks++;
      if (st0 !== 2'b10 || ev0 !== 8'd2) begin
         errors++;
         $display("[TB] FAIL qual_gap_latch got st=%b ev=%0d exp st=10 ev=2", st0, ev0);
      end
   endtask

   task automatic test_blink();
      for (int k = 0; k < 40; k++) begin
         tick(1'($urandom_range(0, 1)), 0, 0, 0);
         checks++;
         if (dut0 !== expVec(0)) begin
            errors++;
            $display("[TB] FAIL blink_cycle%0d got=%h exp=%h", k, dut0, expVec(0));
         end
      end
   endtask

   task automatic test_ack();
      tick(1, 1, 0, 0);
      checks++;
      if (st0 !== 2'b11 || buzz0 !== 1'b0 || lamp0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ack_enter got st=%b buzz=%b lamp=%b exp st=11 buzz=0 lamp=1", st0, buzz0, lamp0);
      end
      for (int k = 0; k < 20; k++) begin
         tick(1, 1'($urandom_range(0, 1)), 0, 0);
         checks++;
         if (dut0 !== expVec(0)) begin
            errors++;
            $display("[TB] FAIL ack_hold%0d got=%h exp=%h", k, dut0, expVec(0));
         end
      end
      tick(0, 0, 0, 0);
      checks++;
      if (dut0 !== {2'b00, 1'b0, 1'b0, 8'd2}) begin
         errors++;
         $display("[TB] FAIL ack_release got=%h exp=%h", dut0, {2'b00, 1'b0, 1'b0, 8'd2});
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4; k++) tick(1, 0, 1, 0);
      checks++;
      if (dut0 !== expVec(0) || st0 !== 2'b10) begin
         errors++;
         $display("[TB] FAIL arst_pre got=%h exp=%h", dut0, expVec(0));
      end
      #3 rstN = 1'b0;
      #1;
      checks++;
      if (dut0 !== 12'h000 || dut1 !== 12'h000) begin
         errors++;
         $display("[TB] FAIL arst_immediate got=%h/%h exp=000/000", dut0, dut1);
      end
      resetModel();
      #2 rstN = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(0, 0, 0, 0);
         checks++;
         if (dut0 !== 12'h000) begin
            errors++;
            $display("[TB] FAIL arst_idle%0d got=%h exp=%h", k, dut0, 12'h000);
         end
      end
   endtask

   task automatic test_debounce1();
      logic [1:0] expSt[3] = '{2'b10, 2'b11, 2'b00};
      logic       pulse[3] = '{1, 0, 0};
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, pulse[k], 1);
         checks++;
         if (st1 !== expSt[k] || dut1 !== expVec(1)) begin
            errors++;
            $display("[TB] FAIL deb1_step%0d got st=%b vec=%h exp st=%b vec=%h", k, st1, dut1, expSt[k], expVec(1));
         end
      end
   endtask

   task automatic test_wrap();
      #3 rstN = 1'b0;
      resetModel();
      #2 rstN = 1'b1;
      for (int n = 1; n <= 256; n++) begin
         tick(0, 0, 1, 0);
         tick(0, 0, 0, 1);
         tick(0, 0, 0, 0);
         if (n == 255 || n == 256) begin
            checks++;
            if (ev1 !== 8'(n % 256) || dut1 !== expVec(1)) begin
               errors++;
               $display("[TB] FAIL wrap_n%0d got ev=%0d vec=%h exp ev=%0d vec=%h", n, ev1, dut1, n % 256, expVec(1));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0));
         checks++;
         if (dut0 !== expVec(0)) begin
            errors++;
            $display("[TB] FAIL rand_inst0_cyc%0d got=%h exp=%h", k, dut0, expVec(0));
         end
         checks++;
         if (dut1 !== expVec(1)) begin
            errors++;
            $display("[TB] FAIL rand_inst1_cyc%0d got=%h exp=%h", k, dut1, expVec(1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_qualification();
      test_blink();
      test_ack();
      test_async_reset();
      test_debounce1();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
